// File: rtl/hazard_control_unit.sv
// ID-stage hazard controller: load-use bubbles, multi-cycle squash on taken
// control transfers, pipeline freeze on memory wait states, saturating perf counters.
module hazard_control_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 idexMemRead,
  input  logic [4:0]           idexRt,
  input  logic [4:0]           ifidRs,
  input  logic [4:0]           ifidRt,
  input  logic                 branchTaken,
  input  logic                 jumpTaken,
  input  logic                 memBusy,
  output logic                 pcWrite,
  output logic                 ifidWrite,
  output logic                 ifidFlush,
  output logic                 ctrl,
  output logic                 ctrlDesvio,
  output logic                 freeze,
  output logic [CNT_WIDTH-1:0] stallCount,
  output logic [CNT_WIDTH-1:0] flushCount,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [2:0]           FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  state_e                saved_q, saved_d;
  state_e                eff_state;
  logic [2:0]            rem_q, rem_d;
  logic [CNT_WIDTH-1:0]  stall_q, stall_d;
  logic [CNT_WIDTH-1:0]  flush_q, flush_d;
  logic                  load_use;

  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] ld_rt,
                                        input logic [4:0] src_rs,
                                        input logic [4:0] src_rt);
    load_use_hit = mem_read && (ld_rt != 5'd0) &&
                   ((ld_rt == src_rs) || (ld_rt == src_rt));
  endfunction

  assign load_use = load_use_hit(idexMemRead, idexRt, ifidRs, ifidRt);

  // After a memory wait, behave as the state that was interrupted.
  always_comb begin
    if (state_q == ST_MEM_WAIT) begin
      eff_state = saved_q;
    end else begin
      eff_state = state_q;
    end
  end

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    ctrl       = 1'b0;
    ctrlDesvio = 1'b0;
    freeze     = 1'b0;
    state_d    = ST_RUN;
    saved_d    = saved_q;
    rem_d      = rem_q;
    if (reset) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      ifidFlush  = 1'b1;
      ctrlDesvio = 1'b1;
      state_d    = ST_RUN;
      saved_d    = ST_RUN;
      rem_d      = 3'd0;
    end else if (memBusy) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      freeze    = 1'b1;
      state_d   = ST_MEM_WAIT;
      saved_d   = eff_state;
    end else if (branchTaken || jumpTaken) begin
      ifidFlush  = 1'b1;
      ctrlDesvio = 1'b1;
      rem_d      = FLUSH_LOAD;
      if (FLUSH_LOAD != 3'd0) begin
        state_d = ST_FLUSH;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (eff_state)
        ST_FLUSH: begin
          ifidFlush  = 1'b1;
          ctrlDesvio = 1'b1;
          if (rem_q > 3'd1) begin
            rem_d   = rem_q - 3'd1;
            state_d = ST_FLUSH;
          end else begin
            rem_d   = 3'd0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
          if (load_use) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            ctrl      = 1'b1;
          end else begin
            pcWrite   = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          rem_d   = 3'd0;
        end
      endcase
    end
  end

  // Saturating performance counters; the reset cycle is never counted.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (reset) begin
      stall_d = {CNT_WIDTH{1'b0}};
      flush_d = {CNT_WIDTH{1'b0}};
    end else begin
      if ((ctrl || freeze) && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + CNT_ONE;
      end else begin
        stall_d = stall_q;
      end
      if (ctrlDesvio && (flush_q != CNT_MAX)) begin
        flush_d = flush_q + CNT_ONE;
      end else begin
        flush_d = flush_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      rem_q   <= 3'd0;
      stall_q <= {CNT_WIDTH{1'b0}};
      flush_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stallCount = stall_q;
  assign flushCount = flush_q;
  assign state      = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scripted-scoreboard bench: each stimulus cycle queues its hand-derived expected
// outputs, which are popped and compared mid-cycle.
module tb_hazard_control_unit;

  logic clock = 1'b0;
  logic reset, idexMemRead, branchTaken, jumpTaken, memBusy;
  logic [4:0] idexRt, ifidRs, ifidRt;
  logic pcWrite, ifidWrite, ifidFlush, ctrl, ctrlDesvio, freeze;
  logic [15:0] stallCount, flushCount;
  logic [1:0] state;
  logic pcWrite_b, ifidWrite_b, ifidFlush_b, ctrl_b, ctrlDesvio_b, freeze_b;
  logic [3:0] stallCount_b, flushCount_b;
  logic [1:0] state_b;

  typedef struct {
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] RST   = 6'b001010;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] FL    = 6'b111010;
  localparam logic [5:0] FRZ   = 6'b000001;

  always #5 clock = ~clock;

  hazard_control_unit #(.FLUSH_CYCLES(3), .CNT_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .idexMemRead(idexMemRead), .idexRt(idexRt),
    .ifidRs(ifidRs), .ifidRt(ifidRt), .branchTaken(branchTaken), .jumpTaken(jumpTaken),
    .memBusy(memBusy), .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .ctrl(ctrl), .ctrlDesvio(ctrlDesvio), .freeze(freeze), .stallCount(stallCount),
    .flushCount(flushCount), .state(state)
  );

  hazard_control_unit #(.FLUSH_CYCLES(1), .CNT_WIDTH(4)) dut_b (
    .clock(clock), .reset(reset), .idexMemRead(idexMemRead), .idexRt(idexRt),
    .ifidRs(ifidRs), .ifidRt(ifidRt), .branchTaken(branchTaken), .jumpTaken(jumpTaken),
    .memBusy(memBusy), .pcWrite(pcWrite_b), .ifidWrite(ifidWrite_b), .ifidFlush(ifidFlush_b),
    .ctrl(ctrl_b), .ctrlDesvio(ctrlDesvio_b), .freeze(freeze_b), .stallCount(stallCount_b),
    .flushCount(flushCount_b), .state(state_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One cycle: drive at posedge+1, queue expectation, compare at negedge.
  task automatic step(input logic rst, input logic mr, input logic [4:0] xrt,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic br, input logic jp, input logic mb,
                      input logic [5:0] ectl, input logic [1:0] est,
                      input logic [15:0] estall, input logic [15:0] eflush);
    exp_t e;
    exp_t got_e;
    @(posedge clock);
    #1;
    reset = rst; idexMemRead = mr; idexRt = xrt; ifidRs = rs; ifidRt = rt;
    branchTaken = br; jumpTaken = jp; memBusy = mb;
    e.ctl = ectl; e.st = est; e.stall = estall; e.flush = eflush;
    exp_q.push_back(e);
    @(negedge clock);
    got_e = exp_q.pop_front();
    check_eq("ctl", {26'd0, pcWrite, ifidWrite, ifidFlush, ctrl, ctrlDesvio, freeze},
             {26'd0, got_e.ctl});
    check_eq("state", {30'd0, state}, {30'd0, got_e.st});
    check_eq("stallCount", {16'd0, stallCount}, {16'd0, got_e.stall});
    check_eq("flushCount", {16'd0, flushCount}, {16'd0, got_e.flush});
  endtask

  initial begin
    reset = 1'b1; idexMemRead = 1'b0; idexRt = 5'd0; ifidRs = 5'd0; ifidRt = 5'd0;
    branchTaken = 1'b0; jumpTaken = 1'b0; memBusy = 1'b0;
    @(posedge clock);
    //    rst  mr   xrt    rs     rt     br   jp   mb    ctl    st     stall   flush
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RST,   2'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd0, 16'd0);
    // load-use on rs, then bubble, then rt=0 no-hazard, then match on rt
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, STALL, 2'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd1, 16'd0);
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd1, 16'd0);
    step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, STALL, 2'd0, 16'd1, 16'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd2, 16'd0);
    // branch: three squash cycles
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, FL,    2'd0, 16'd2, 16'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FL,    2'd1, 16'd2, 16'd1);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FL,    2'd1, 16'd2, 16'd2);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd2, 16'd3);
    // jump, then memBusy x4 during the second squash cycle
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, FL,    2'd0, 16'd2, 16'd3);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   2'd1, 16'd2, 16'd4);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, FRZ,   2'd2, 16'd3, 16'd4);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   2'd2, 16'd4, 16'd4);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   2'd2, 16'd5, 16'd4);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FL,    2'd2, 16'd6, 16'd4);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FL,    2'd1, 16'd6, 16'd5);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd6, 16'd6);
    // branch together with load-use: flush wins; hazard suppressed in FLUSH
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, FL,    2'd0, 16'd6, 16'd6);
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, FL,    2'd1, 16'd6, 16'd7);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FL,    2'd1, 16'd6, 16'd8);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd6, 16'd9);
    // memBusy masks a load-use; the stall appears on release
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   2'd0, 16'd6, 16'd9);
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, STALL, 2'd2, 16'd7, 16'd9);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd8, 16'd9);
    // reset during FLUSH, then during MEM_WAIT
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, FL,    2'd0, 16'd8, 16'd9);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RST,   2'd1, 16'd8, 16'd10);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ,   2'd0, 16'd0, 16'd0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, RST,   2'd2, 16'd1, 16'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd0, 16'd0);
    // branch during FLUSH reloads the squash count
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, FL,    2'd0, 16'd0, 16'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, FL,    2'd1, 16'd0, 16'd1);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FL,    2'd1, 16'd0, 16'd2);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, FL,    2'd1, 16'd0, 16'd3);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd0, 16'd4);
    // continuous load-use: 4-bit counter on dut_b saturates at 15
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, STALL, 2'd0, 16'(i), 16'd4);
      check_eq("sat_stall_b", {28'd0, stallCount_b}, (i < 15) ? i : 32'd15);
    end
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NORM,  2'd0, 16'd20, 16'd4);
    check_eq("sat_stall_b_final", {28'd0, stallCount_b}, 32'd15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
